rf_writeback: RTL

Write-port controller for the 32x32 register file in the RV32I core; drives the RF's rd/data_in/we inputs. Merges single-cycle ALU results, which always take priority, with multi-cycle load results. Load results arrive through a valid/ready handshake and wait in a small FIFO until the RF write port is free. Supplies pending-write bypass data for rs1/rs2, because a RF read on the write edge returns the old value.

---
 rtl/rf_writeback.sv | 139 +++++++++++++
 1 files changed

// File: rtl/rf_writeback.sv
// Register-file write-port controller: ALU results take the port first, and load
// results wait in a small FIFO. It also provides pending-write bypass for rs1/rs2.
module rf_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  input  logic [4:0]      byp_rs1,
  input  logic [4:0]      byp_rs2,
  output logic            byp_hit1,
  output logic            byp_hit2,
  output logic [XLEN-1:0] byp_data1,
  output logic [XLEN-1:0] byp_data2,
  output logic [31:0]     pend_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      ent_rd   [DEPTH];
  logic [XLEN-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0] ent_live;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic alu_sel;
  logic ld_fire;
  logic push;
  logic pop;
  logic head_live;
  logic ld_sel;

  // Load handshake: a transfer happens on a rising edge where ld_valid && ld_ready.
  // ld_ready depends only on rst and count, so a full FIFO never takes a load,
  // even in a cycle where the head pops.
  assign ld_ready  = !rst && (count < CW'(DEPTH));
  assign ld_fire   = ld_valid && ld_ready;
  assign push      = ld_fire && (ld_rd != 5'd0);
  assign alu_sel   = alu_valid && (alu_rd != 5'd0);
  // Live bits are cleared on pop, so an empty FIFO never shows a live head.
  assign head_live = ent_live[head];
  assign pop       = (count != '0) && (!head_live || !alu_sel);
  assign ld_sel    = pop && head_live;

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ent_live <= '0;
      rf_we    <= 1'b0;
      rf_rd    <= 5'd0;
      rf_data  <= '0;
    end else begin
      // A younger ALU write to the same rd makes buffered loads dead.
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_sel && (ent_rd[i] == alu_rd)) begin
          ent_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_live[head] <= 1'b0;
        head           <= head + PW'(1);
      end
      // Placed after the kill loop so a same-cycle push stays live.
      if (push) begin
        ent_rd[tail]   <= ld_rd;
        ent_data[tail] <= ld_data;
        ent_live[tail] <= 1'b1;
        tail           <= tail + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);

      if (alu_sel) begin
        rf_we   <= 1'b1;
        rf_rd   <= alu_rd;
        rf_data <= alu_data;
      end else if (ld_sel) begin
        rf_we   <= 1'b1;
        rf_rd   <= ent_rd[head];
        rf_data <= ent_data[head];
      end else begin
        rf_we   <= 1'b0;
      end
    end
  end

  // Returns {hit, data}. The FIFO is scanned oldest to youngest, so the youngest
  // live match overrides the output stage and any older entries.
  function automatic logic [XLEN:0] lookup(input logic [4:0] rs);
    logic [XLEN:0]  res;
    logic [PW-1:0]  idx;
    res = '0;
    if (rf_we && (rf_rd == rs)) begin
      res = {1'b1, rf_data};
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (ent_live[idx] && (ent_rd[idx] == rs)) begin
        res = {1'b1, ent_data[idx]};
      end
    end
    if (rs == 5'd0) begin
      res = '0;
    end
    return res;
  endfunction

  always_comb begin
    {byp_hit1, byp_data1} = lookup(byp_rs1);
    {byp_hit2, byp_data2} = lookup(byp_rs2);
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_live[i]) begin
        pend_mask[ent_rd[i]] = 1'b1;
      end
    end
    if (rf_we) begin
      pend_mask[rf_rd] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

endmodule
